// File: rtl/ddr_bank_cmd_gate.sv
// ddr_bank_cmd_gate
// Single-bank DDR command timing gate between the command sequencer and the
// PHY command register. Legal commands are held off until their DRAM timing
// windows have elapsed. Illegal commands are consumed and flagged with an
// error pulse. Accepted commands reach the PHY exactly one cycle later.
module ddr_bank_cmd_gate #(
    parameter int T_RCD = 3,
    parameter int T_RAS = 8,
    parameter int T_RP  = 3,
    parameter int T_RFC = 12,
    parameter int T_CCD = 2,
    parameter int CNT_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [2:0] cmd,
    output logic       cmd_ready,
    output logic       issue_valid,
    output logic [2:0] issue_cmd,
    output logic       cmd_err,
    output logic       bank_open,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_OPENING = 3'd1,
        ST_OPEN    = 3'd2,
        ST_CLOSING = 3'd3,
        ST_REFRESH = 3'd4
    } state_t;

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    // Timer reload values: a load of T-1 on the accepting cycle makes the
    // timer read zero exactly T cycles after that acceptance.
    localparam logic [CNT_W-1:0] L_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] L_RCD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] L_RAS = CNT_W'(T_RAS - 1);
    localparam logic [CNT_W-1:0] L_RP  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] L_RFC = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] L_CCD = CNT_W'(T_CCD - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_rcd_cnt;
    logic [CNT_W-1:0] r_ras_cnt;
    logic [CNT_W-1:0] r_rp_cnt;   // shared by tRP and tRFC
    logic [CNT_W-1:0] r_ccd_cnt;
    logic             r_issue_valid;
    logic [2:0]       r_issue_cmd;
    logic             r_cmd_err;
    logic             r_bank_open;
    logic             r_busy;

    logic             w_open;
    logic             w_legal;
    logic             w_timing_ok;
    logic             w_accept;
    logic             w_issue;
    logic             w_drop;
    state_t           w_next_state;

    // Saturating decrement: a timer parks at zero once its window has passed.
    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - L_ONE;
    endfunction

    assign w_open = (r_state == ST_OPENING) || (r_state == ST_OPEN);

    // Classify the presented command: legal in this state, and timing met.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_legal     = 1'b0;
        w_timing_ok = 1'b1;
        case (cmd)
            CMD_NOP: w_legal = 1'b1;
            CMD_ACT, CMD_REF: begin
                w_legal     = !w_open;
                w_timing_ok = (r_rp_cnt == '0);
            end
            CMD_RD, CMD_WR: begin
                w_legal     = w_open;
                w_timing_ok = (r_rcd_cnt == '0) && (r_ccd_cnt == '0);
            end
            CMD_PRE: begin
                w_legal     = w_open;
                w_timing_ok = (r_ras_cnt == '0);
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Illegal commands and NOPs are always taken. A legal command waits for
    // its timers. Nothing is taken while reset is held.
    assign cmd_ready = !rst && (!w_legal || w_timing_ok);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_issue   = w_accept && w_legal && (cmd != CMD_NOP);
    assign w_drop    = w_accept && !w_legal;

    // Next bank state: issued commands start a wait, and timers end waits.
    always_comb begin
        w_next_state = r_state;
        if (w_issue && (cmd == CMD_ACT)) begin
            w_next_state = (T_RCD == 1) ? ST_OPEN : ST_OPENING;
        end else if (w_issue && (cmd == CMD_PRE)) begin
            w_next_state = (T_RP == 1) ? ST_CLOSED : ST_CLOSING;
        end else if (w_issue && (cmd == CMD_REF)) begin
            w_next_state = (T_RFC == 1) ? ST_CLOSED : ST_REFRESH;
        end else begin
            case (r_state)
                ST_OPENING: if (r_rcd_cnt <= L_ONE) w_next_state = ST_OPEN;
                ST_CLOSING,
                ST_REFRESH: if (r_rp_cnt <= L_ONE) w_next_state = ST_CLOSED;
                default:    w_next_state = r_state;
            endcase
        end
    end

    // Timing windows: reload on the accepting cycle, otherwise count down.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments, so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            r_rcd_cnt <= '0;
            r_ras_cnt <= '0;
            r_rp_cnt  <= '0;
            r_ccd_cnt <= '0;
        end else begin
            r_rcd_cnt <= (w_issue && cmd == CMD_ACT) ? L_RCD : sat_dec(r_rcd_cnt);
            r_ras_cnt <= (w_issue && cmd == CMD_ACT) ? L_RAS : sat_dec(r_ras_cnt);
            if (w_issue && cmd == CMD_PRE)
                r_rp_cnt <= L_RP;
            else if (w_issue && cmd == CMD_REF)
                r_rp_cnt <= L_RFC;
            else
                r_rp_cnt <= sat_dec(r_rp_cnt);
            r_ccd_cnt <= (w_issue && (cmd == CMD_RD || cmd == CMD_WR)) ?
                         L_CCD : sat_dec(r_ccd_cnt);
        end
    end

    // Bank FSM with registered PHY issue, error pulse and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_CLOSED;
            r_issue_valid <= 1'b0;
            r_issue_cmd   <= 3'd0;
            r_cmd_err     <= 1'b0;
            r_bank_open   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_issue_valid <= w_issue;
            r_issue_cmd   <= w_issue ? cmd : 3'd0;
            r_cmd_err     <= w_drop;
            r_bank_open   <= (w_next_state == ST_OPENING) || (w_next_state == ST_OPEN);
            r_busy        <= (w_next_state == ST_OPENING) || (w_next_state == ST_CLOSING) ||
                             (w_next_state == ST_REFRESH);
        end
    end

    assign issue_valid = r_issue_valid;
    assign issue_cmd   = r_issue_cmd;
    assign cmd_err     = r_cmd_err;
    assign bank_open   = r_bank_open;
    assign busy        = r_busy;

endmodule

// File: tb/tb_ddr_bank_cmd_gate.sv
// Testbench for ddr_bank_cmd_gate. Instance A uses the default timing and
// instance B uses the fast corner (tRCD=tRP=tRFC=tCCD=1, tRAS=3). A
// reference model tracks, per instance, the cycle of the last ACT, PRE,
// REF and RD/WR acceptance. It derives readiness, issue, error, bank_open
// and busy from those cycle numbers.
module tb_ddr_bank_cmd_gate;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, b_valid;
    logic [2:0] a_cmd, b_cmd;
    logic       a_ready, a_iv, a_err, a_bo, a_busy;
    logic       b_ready, b_iv, b_err, b_bo, b_busy;
    logic [2:0] a_ic, b_ic;

    always #5 clk = ~clk;

    ddr_bank_cmd_gate u_a (
        .clk(clk), .rst(rst), .cmd_valid(a_valid), .cmd(a_cmd),
        .cmd_ready(a_ready), .issue_valid(a_iv), .issue_cmd(a_ic),
        .cmd_err(a_err), .bank_open(a_bo), .busy(a_busy)
    );

    ddr_bank_cmd_gate #(.T_RCD(1), .T_RAS(3), .T_RP(1), .T_RFC(1), .T_CCD(1)) u_b (
        .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd(b_cmd),
        .cmd_ready(b_ready), .issue_valid(b_iv), .issue_cmd(b_ic),
        .cmd_err(b_err), .bank_open(b_bo), .busy(b_busy)
    );

    localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3,
                           PRE = 3'd4, REF = 3'd5;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state, index 0 = instance A, 1 = instance B.
    int   p_rcd[2] = '{3, 1};
    int   p_ras[2] = '{8, 3};
    int   p_rp[2]  = '{3, 1};
    int   p_rfc[2] = '{12, 1};
    int   p_ccd[2] = '{2, 1};
    int   last_act[2], last_pre[2], last_ref[2], last_rw[2];
    bit   open_m[2];
    bit   exp_iv[2];
    bit   exp_err[2];
    logic [2:0] exp_ic[2];

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic get_ready(input int d); return (d == 0) ? a_ready : b_ready; endfunction
    function automatic logic get_iv(input int d);    return (d == 0) ? a_iv    : b_iv;    endfunction
    function automatic logic get_err(input int d);   return (d == 0) ? a_err   : b_err;   endfunction
    function automatic logic get_bo(input int d);    return (d == 0) ? a_bo    : b_bo;    endfunction
    function automatic logic get_busy(input int d);  return (d == 0) ? a_busy  : b_busy;  endfunction
    function automatic logic [2:0] get_ic(input int d); return (d == 0) ? a_ic : b_ic;    endfunction

    function automatic bit m_legal(input int d, input logic [2:0] c);
        case (c)
            NOP:      return 1'b1;
            ACT, REF: return !open_m[d];
            RD, WR, PRE: return open_m[d];
            default:  return 1'b0;
        endcase
    endfunction

    function automatic bit m_time_ok(input int d, input logic [2:0] c);
        case (c)
            ACT, REF: return (cyc >= last_pre[d] + p_rp[d]) && (cyc >= last_ref[d] + p_rfc[d]);
            RD, WR:   return (cyc >= last_act[d] + p_rcd[d]) && (cyc >= last_rw[d] + p_ccd[d]);
            PRE:      return cyc >= last_act[d] + p_ras[d];
            default:  return 1'b1;
        endcase
    endfunction

    function automatic bit m_busy(input int d);
        if (open_m[d]) return cyc < last_act[d] + p_rcd[d];
        return (cyc < last_pre[d] + p_rp[d]) || (cyc < last_ref[d] + p_rfc[d]);
    endfunction

    task automatic model_reset();
        for (int e = 0; e < 2; e++) begin
            last_act[e] = -1000; last_pre[e] = -1000;
            last_ref[e] = -1000; last_rw[e]  = -1000;
            open_m[e] = 1'b0; exp_iv[e] = 1'b0; exp_err[e] = 1'b0; exp_ic[e] = 3'd0;
        end
    endtask

    // One clock cycle on instance d: drive, check outputs, advance the model.
    task automatic cycle(input int d, input bit v, input logic [2:0] c, output bit dut_acc);
        bit legal, m_rdy, m_acc;
        @(negedge clk);
        a_valid = (d == 0) && v; a_cmd = c;
        b_valid = (d == 1) && v; b_cmd = c;
        #1;
        check_bit($sformatf("issue_valid[%0d]@%0d", d, cyc), get_iv(d), exp_iv[d]);
        if (exp_iv[d])
            check_val($sformatf("issue_cmd[%0d]@%0d", d, cyc), 32'(get_ic(d)), 32'(exp_ic[d]));
        check_bit($sformatf("cmd_err[%0d]@%0d", d, cyc), get_err(d), exp_err[d]);
        check_bit($sformatf("bank_open[%0d]@%0d", d, cyc), get_bo(d), open_m[d]);
        check_bit($sformatf("busy[%0d]@%0d", d, cyc), get_busy(d), m_busy(d));
        legal = m_legal(d, c);
        m_rdy = !legal || m_time_ok(d, c);
        if (v) check_bit($sformatf("cmd_ready[%0d]@%0d cmd=%0d", d, cyc, c), get_ready(d), m_rdy);
        dut_acc = v && (get_ready(d) === 1'b1);
        m_acc   = v && m_rdy;
        for (int e = 0; e < 2; e++) begin
            exp_iv[e]  = 1'b0;
            exp_err[e] = 1'b0;
        end
        exp_iv[d]  = m_acc && legal && (c != NOP);
        exp_ic[d]  = c;
        exp_err[d] = m_acc && !legal;
        if (m_acc && legal) begin
            case (c)
                ACT: begin last_act[d] = cyc; open_m[d] = 1'b1; end
                PRE: begin last_pre[d] = cyc; open_m[d] = 1'b0; end
                REF: last_ref[d] = cyc;
                RD, WR: last_rw[d] = cyc;
                default: ;
            endcase
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(input int d, input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(d, 1'b0, NOP, acc);
    endtask

    // Hold a legal command valid until taken. Return the acceptance cycle.
    task automatic hold(input int d, input logic [2:0] c, input string tag, output int at);
        bit acc;
        at = -1;
        for (int i = 0; i < 40; i++) begin
            cycle(d, 1'b1, c, acc);
            if (acc) begin
                at = cyc - 1;
                break;
            end
        end
        check_bit({tag, "_taken_within_bound"}, at >= 0, 1'b1);
        if (at >= 0) begin
            #1;
            check_bit({tag, "_issue_next_cycle"}, get_iv(d), 1'b1);
            check_val({tag, "_issue_cmd"}, 32'(get_ic(d)), 32'(c));
        end
    endtask

    // Present an illegal command for one cycle and confirm it is dropped.
    task automatic drop(input int d, input logic [2:0] c, input string tag);
        bit acc;
        bit bo_exp;
        bo_exp = open_m[d];
        cycle(d, 1'b1, c, acc);
        check_bit({tag, "_consumed"}, acc, 1'b1);
        #1;
        check_bit({tag, "_cmd_err"}, get_err(d), 1'b1);
        check_bit({tag, "_no_issue"}, get_iv(d), 1'b0);
        check_bit({tag, "_state_kept"}, get_bo(d), bo_exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        a_valid = 1'b1; a_cmd = ACT;
        b_valid = 1'b1; b_cmd = ACT;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_bit($sformatf("rst_ready[%0d]", d), get_ready(d), 1'b0);
            check_bit($sformatf("rst_issue_valid[%0d]", d), get_iv(d), 1'b0);
            check_val($sformatf("rst_issue_cmd[%0d]", d), 32'(get_ic(d)), 32'd0);
            check_bit($sformatf("rst_cmd_err[%0d]", d), get_err(d), 1'b0);
            check_bit($sformatf("rst_bank_open[%0d]", d), get_bo(d), 1'b0);
            check_bit($sformatf("rst_busy[%0d]", d), get_busy(d), 1'b0);
        end
        model_reset();
        @(posedge clk);
        #1;
        check_bit("rst_act_not_taken_a", a_iv, 1'b0);
        check_bit("rst_act_not_taken_b", b_iv, 1'b0);
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, t1, at, k;
        bit acc;
        rst = 1'b1;
        a_valid = 1'b0; a_cmd = NOP;
        b_valid = 1'b0; b_cmd = NOP;
        model_reset();
        do_reset();
        idle(0, 2);

        // Reset in the middle of a refresh wait.
        hold(0, REF, "ref_pre_reset", at);
        idle(0, 3);
        do_reset();
        t0 = cyc;
        hold(0, ACT, "act_after_reset", at);
        check_val("act_immediate_after_reset", at, t0);

        // tRCD / tCCD / tRAS / tRP with default timing.
        hold(0, RD, "rd", at);
        check_val("rd_after_trcd", at, t0 + 3);
        hold(0, WR, "wr", at);
        check_val("wr_after_tccd", at, t0 + 5);
        hold(0, PRE, "pre", at);
        check_val("pre_after_tras", at, t0 + 8);
        hold(0, ACT, "act2", at);
        check_val("act_after_trp", at, t0 + 11);
        check_bit("bank_open_after_act2", a_bo, 1'b1);

        // Illegal commands are consumed and flagged.
        idle(0, 4);
        drop(0, ACT, "act_in_open");
        hold(0, PRE, "pre2", at);
        idle(0, 4);
        drop(0, RD, "rd_in_closed");
        drop(0, 3'd7, "cmd7");
        drop(0, 3'd6, "cmd6");

        // tRFC.
        t1 = cyc;
        hold(0, REF, "ref", at);
        check_val("ref_immediate", at, t1);
        hold(0, ACT, "act_after_ref", at);
        check_val("act_after_trfc", at, t1 + 12);

        // Fast corner instance: five commands on consecutive cycles.
        hold(1, ACT, "b_act", k);
        hold(1, RD, "b_rd1", at);
        check_val("b_rd1_cycle", at, k + 1);
        hold(1, RD, "b_rd2", at);
        check_val("b_rd2_cycle", at, k + 2);
        hold(1, PRE, "b_pre", at);
        check_val("b_pre_cycle", at, k + 3);
        hold(1, ACT, "b_act2", at);
        check_val("b_act2_cycle", at, k + 4);

        // Randomized traffic against the model on both instances.
        for (int i = 0; i < 600; i++) begin
            int d;
            bit v;
            logic [2:0] c;
            d = (i < 400) ? 0 : 1;
            v = ($urandom_range(0, 3) != 0);
            c = 3'($urandom_range(0, 7));
            cycle(d, v, c, acc);
        end
        idle(0, 1);
        idle(1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
